// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use hazard detection, bubble insertion on
// stall or branch flush, and saturating stall/flush counters.
module id_ex_hazard_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              arst,
  input  logic              enable,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [7:0]        id_ctrl,
  output logic              ex_valid,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [7:0]        ex_ctrl,
  output logic              stall,
  output logic              pc_write,
  output logic              if_id_write,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic hz;

  // A load to $0 never creates a dependency, so ex_rt == 0 is excluded.
  assign hz = ex_valid & ex_ctrl[6] & (ex_rt != 5'd0) & id_valid &
              ((ex_rt == id_rs) | (ex_rt == id_rt));

  // Flush wins so the PC is free to take the branch target.
  assign stall       = hz & ~flush;
  assign pc_write    = ~stall;
  assign if_id_write = ~stall;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      ex_valid   <= 1'b0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_ctrl    <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else if (enable) begin
      if (flush || stall) begin
        ex_valid   <= 1'b0;
        ex_rs      <= '0;
        ex_rt      <= '0;
        ex_rd      <= '0;
        ex_rs_data <= '0;
        ex_rt_data <= '0;
        ex_imm     <= '0;
        ex_ctrl    <= '0;
        if (flush) begin
          if (flush_cnt != CNT_MAX) flush_cnt <= flush_cnt + 1'b1;
        end else begin
          if (stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
        end
      end else begin
        ex_valid   <= id_valid;
        ex_rs      <= id_rs;
        ex_rt      <= id_rt;
        ex_rd      <= id_rd;
        ex_rs_data <= id_rs_data;
        ex_rt_data <= id_rt_data;
        ex_imm     <= id_imm;
        // An invalid slot must never carry write/read enables into EX.
        ex_ctrl    <= id_valid ? id_ctrl : 8'h00;
      end
    end
  end

endmodule
